rob_retire_buffer: RTL and testbench

- Reorder buffer for the out-of-order MIPS core.
- Dispatch allocates one slot per instruction. Execution units write results back out of order, tagged with that slot and its stream.
- The buffer supplies operand forwarding lookups to issue and retires completed entries in program order to the register file.
- On a branch misprediction it squashes every slot younger than a given slot.

---
 rtl/rob_retire_buffer.sv | 166 ++++++++++++++++
 tb/tb_rob_retire_buffer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_retire_buffer.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order single retire, squash-after-slot flush.
// Optional macro ROB_FWD_BYPASS_EN bypasses a same-cycle accepted writeback into the operand lookups.
module rob_retire_buffer #(
  parameter int DEPTH  = 32,
  parameter int SLOT_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_req,
  input  logic [4:0]        alloc_dest_reg,
  input  logic              alloc_dest_reg_valid,
  input  logic              alloc_stream,
  output logic              alloc_ok,
  output logic [SLOT_W-1:0] alloc_slot,
  input  logic              wb_valid,
  input  logic [SLOT_W-1:0] wb_slot,
  input  logic              wb_stream,
  input  logic [31:0]       wb_result_hi,
  input  logic [31:0]       wb_result_lo,
  input  logic              wb_inval,
  input  logic [SLOT_W-1:0] fwd_A_slot,
  input  logic [SLOT_W-1:0] fwd_B_slot,
  output logic              fwd_A_ready,
  output logic              fwd_B_ready,
  output logic [31:0]       fwd_A_data,
  output logic [31:0]       fwd_B_data,
  input  logic              flush_valid,
  input  logic [SLOT_W-1:0] flush_slot,
  output logic              commit_valid,
  output logic [4:0]        commit_dest_reg,
  output logic              commit_dest_reg_valid,
  output logic [31:0]       commit_result_hi,
  output logic [31:0]       commit_result_lo,
  output logic              commit_stream,
  output logic [SLOT_W:0]   count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [4:0]  dest_reg;
    logic        dest_reg_valid;
    logic        stream;
    logic [31:0] result_hi;
    logic [31:0] result_lo;
  } rob_entry_t;

  rob_entry_t       entries [DEPTH];
  logic [DEPTH-1:0] pc_valid;
  logic [DEPTH-1:0] done;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [SLOT_W:0]  count_next;

  logic [PTR_W-1:0] wb_idx;
  logic [PTR_W-1:0] flush_idx;
  logic [PTR_W-1:0] flush_off;
  logic [PTR_W-1:0] fwd_a_idx;
  logic [PTR_W-1:0] fwd_b_idx;
  logic [DEPTH-1:0] squash;
  logic             alloc_fire;
  logic             retire;
  logic             wb_hit;

  assign wb_idx    = PTR_W'(wb_slot);
  assign flush_idx = PTR_W'(flush_slot);
  assign fwd_a_idx = PTR_W'(fwd_A_slot);
  assign fwd_b_idx = PTR_W'(fwd_B_slot);
  assign flush_off = flush_idx - head;

  assign alloc_ok   = (count != (SLOT_W+1)'(DEPTH));
  assign alloc_slot = SLOT_W'(tail);
  assign alloc_fire = alloc_req && alloc_ok && !flush_valid;

  assign commit_valid          = pc_valid[head] && done[head] && (count != '0);
  assign retire                = commit_valid;
  assign commit_dest_reg       = entries[head].dest_reg;
  assign commit_dest_reg_valid = commit_valid && entries[head].dest_reg_valid;
  assign commit_result_hi      = entries[head].result_hi;
  assign commit_result_lo      = entries[head].result_lo;
  assign commit_stream         = entries[head].stream;

  // Squashed: program-order offset from head lies after flush_slot and before the old tail.
  always_comb begin
    logic [PTR_W-1:0] off;
    off    = '0;
    squash = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off       = PTR_W'(i) - head;
      squash[i] = flush_valid && (off > flush_off) && ((SLOT_W+1)'(off) < count);
    end
  end

  assign wb_hit = wb_valid && pc_valid[wb_idx] && (entries[wb_idx].stream == wb_stream)
                  && !squash[wb_idx];

  always_comb begin
    fwd_A_ready = pc_valid[fwd_a_idx] && done[fwd_a_idx];
    fwd_A_data  = entries[fwd_a_idx].result_lo;
    fwd_B_ready = pc_valid[fwd_b_idx] && done[fwd_b_idx];
    fwd_B_data  = entries[fwd_b_idx].result_lo;
`ifdef ROB_FWD_BYPASS_EN
    if (wb_hit && (wb_slot == fwd_A_slot)) begin
      fwd_A_ready = 1'b1;
      fwd_A_data  = wb_result_lo;
    end
    if (wb_hit && (wb_slot == fwd_B_slot)) begin
      fwd_B_ready = 1'b1;
      fwd_B_data  = wb_result_lo;
    end
`endif
  end

  // Flush redefines occupancy from head to flush_slot; a same-cycle retire still removes head.
  always_comb begin
    count_next = count;
    if (flush_valid)
      count_next = (SLOT_W+1)'(flush_off) + (SLOT_W+1)'(1);
    else if (alloc_fire)
      count_next = count + (SLOT_W+1)'(1);
    if (retire)
      count_next = count_next - (SLOT_W+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      pc_valid <= '0;
      done     <= '0;
    end else begin
      count <= count_next;
      if (flush_valid) begin
        pc_valid <= pc_valid & ~squash;
        done     <= done & ~squash;
        tail     <= flush_idx + PTR_W'(1);
      end
      if (wb_hit)
        done[wb_idx] <= 1'b1;
      if (alloc_fire) begin
        pc_valid[tail] <= 1'b1;
        done[tail]     <= 1'b0;
        tail           <= tail + PTR_W'(1);
      end
      if (retire) begin
        pc_valid[head] <= 1'b0;
        done[head]     <= 1'b0;
        head           <= head + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wb_hit) begin
      entries[wb_idx].result_hi <= wb_result_hi;
      entries[wb_idx].result_lo <= wb_result_lo;
      if (wb_inval)
        entries[wb_idx].dest_reg_valid <= 1'b0;
    end
    if (alloc_fire) begin
      entries[tail].dest_reg       <= alloc_dest_reg;
      entries[tail].dest_reg_valid <= alloc_dest_reg_valid;
      entries[tail].stream         <= alloc_stream;
    end
  end
endmodule

// File: tb/tb_rob_retire_buffer.sv
// Bench for rob_retire_buffer: program-order queue model checked every cycle, plus directed literal checks.
module tb_rob_retire_buffer;
  localparam int DEPTH  = 32;
  localparam int SLOT_W = 7;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              alloc_req = 1'b0;
  logic [4:0]        alloc_dest_reg = '0;
  logic              alloc_dest_reg_valid = 1'b0;
  logic              alloc_stream = 1'b0;
  logic              alloc_ok;
  logic [SLOT_W-1:0] alloc_slot;
  logic              wb_valid = 1'b0;
  logic [SLOT_W-1:0] wb_slot = '0;
  logic              wb_stream = 1'b0;
  logic [31:0]       wb_result_hi = '0;
  logic [31:0]       wb_result_lo = '0;
  logic              wb_inval = 1'b0;
  logic [SLOT_W-1:0] fwd_A_slot = '0;
  logic [SLOT_W-1:0] fwd_B_slot = '0;
  logic              fwd_A_ready;
  logic              fwd_B_ready;
  logic [31:0]       fwd_A_data;
  logic [31:0]       fwd_B_data;
  logic              flush_valid = 1'b0;
  logic [SLOT_W-1:0] flush_slot = '0;
  logic              commit_valid;
  logic [4:0]        commit_dest_reg;
  logic              commit_dest_reg_valid;
  logic [31:0]       commit_result_hi;
  logic [31:0]       commit_result_lo;
  logic              commit_stream;
  logic [SLOT_W:0]   count;

  always #5 clock = ~clock;

  rob_retire_buffer #(.DEPTH(DEPTH), .SLOT_W(SLOT_W)) dut (
    .clock(clock), .reset(reset),
    .alloc_req(alloc_req), .alloc_dest_reg(alloc_dest_reg),
    .alloc_dest_reg_valid(alloc_dest_reg_valid), .alloc_stream(alloc_stream),
    .alloc_ok(alloc_ok), .alloc_slot(alloc_slot),
    .wb_valid(wb_valid), .wb_slot(wb_slot), .wb_stream(wb_stream),
    .wb_result_hi(wb_result_hi), .wb_result_lo(wb_result_lo), .wb_inval(wb_inval),
    .fwd_A_slot(fwd_A_slot), .fwd_B_slot(fwd_B_slot),
    .fwd_A_ready(fwd_A_ready), .fwd_B_ready(fwd_B_ready),
    .fwd_A_data(fwd_A_data), .fwd_B_data(fwd_B_data),
    .flush_valid(flush_valid), .flush_slot(flush_slot),
    .commit_valid(commit_valid), .commit_dest_reg(commit_dest_reg),
    .commit_dest_reg_valid(commit_dest_reg_valid),
    .commit_result_hi(commit_result_hi), .commit_result_lo(commit_result_lo),
    .commit_stream(commit_stream), .count(count)
  );

  typedef struct {
    logic [4:0]  dest;
    logic        dvalid;
    logic        stream;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
  } m_entry_t;

  m_entry_t    q[$];
  int unsigned mhead = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          model_live = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned off_of(input logic [SLOT_W-1:0] s);
    return (int'(s) + DEPTH - mhead) % DEPTH;
  endfunction

  function automatic bit wb_accepted();
    int unsigned k;
    k = off_of(wb_slot);
    return wb_valid && (k < q.size()) && (q[k].stream == wb_stream)
           && !(flush_valid && (k > off_of(flush_slot)));
  endfunction

  function automatic void fwd_model(input logic [SLOT_W-1:0] s, output bit r, output logic [31:0] d);
    int unsigned k;
    k = off_of(s);
    r = 1'b0;
    d = '0;
    if (k < q.size() && q[k].done) begin
      r = 1'b1;
      d = q[k].lo;
    end
`ifdef ROB_FWD_BYPASS_EN
    if (wb_accepted() && wb_slot == s) begin
      r = 1'b1;
      d = wb_result_lo;
    end
`endif
  endfunction

  task automatic model_step();
    int unsigned fo, k, keep;
    bit ret, acc, wacc;
    fo   = off_of(flush_slot);
    ret  = (q.size() > 0) && q[0].done;
    acc  = alloc_req && (q.size() < DEPTH) && !flush_valid;
    wacc = wb_accepted();
    if (wacc) begin
      k = off_of(wb_slot);
      q[k].done = 1'b1;
      q[k].hi   = wb_result_hi;
      q[k].lo   = wb_result_lo;
      if (wb_inval) q[k].dvalid = 1'b0;
    end
    if (ret) begin
      void'(q.pop_front());
      mhead = (mhead + 1) % DEPTH;
    end
    if (flush_valid) begin
      keep = ret ? fo : fo + 1;
      while (q.size() > keep) void'(q.pop_back());
    end
    if (acc)
      q.push_back('{alloc_dest_reg, alloc_dest_reg_valid, alloc_stream, 1'b0, 32'h0, 32'h0});
  endtask

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      mhead = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      model_step();
    end
  end

  always @(negedge clock) begin
    int unsigned sz;
    bit cv, r;
    logic [31:0] d;
    if (model_live && !reset) begin
      sz = q.size();
      chk("count", 64'(count), 64'(sz));
      chk("alloc_ok", 64'(alloc_ok), 64'(sz < DEPTH));
      chk("alloc_slot", 64'(alloc_slot), 64'((mhead + sz) % DEPTH));
      cv = 1'b0;
      if (sz > 0) cv = q[0].done;
      chk("commit_valid", 64'(commit_valid), 64'(cv));
      if (cv) begin
        chk("commit_dest_reg", 64'(commit_dest_reg), 64'(q[0].dest));
        chk("commit_dest_reg_valid", 64'(commit_dest_reg_valid), 64'(q[0].dvalid));
        chk("commit_result_hi", 64'(commit_result_hi), 64'(q[0].hi));
        chk("commit_result_lo", 64'(commit_result_lo), 64'(q[0].lo));
        chk("commit_stream", 64'(commit_stream), 64'(q[0].stream));
      end else begin
        chk("commit_dest_reg_valid_idle", 64'(commit_dest_reg_valid), 64'(0));
      end
      fwd_model(fwd_A_slot, r, d);
      chk("fwd_A_ready", 64'(fwd_A_ready), 64'(r));
      if (r) chk("fwd_A_data", 64'(fwd_A_data), 64'(d));
      fwd_model(fwd_B_slot, r, d);
      chk("fwd_B_ready", 64'(fwd_B_ready), 64'(r));
      if (r) chk("fwd_B_data", 64'(fwd_B_data), 64'(d));
    end
  end

  task automatic idle();
    alloc_req   = 1'b0;
    wb_valid    = 1'b0;
    wb_inval    = 1'b0;
    flush_valid = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    idle();
    #1;
  endtask

  task automatic alloc(input int unsigned r, input logic s);
    alloc_req = 1'b1;
    alloc_dest_reg = 5'(r);
    alloc_dest_reg_valid = 1'b1;
    alloc_stream = s;
    cyc();
  endtask

  task automatic set_wb(input int unsigned slot, input logic s, input logic [31:0] lo, input logic inval);
    wb_valid = 1'b1;
    wb_slot = SLOT_W'(slot);
    wb_stream = s;
    wb_result_lo = lo;
    wb_result_hi = ~lo;
    wb_inval = inval;
  endtask

  task automatic wb(input int unsigned slot, input logic s, input logic [31:0] lo, input logic inval);
    set_wb(slot, s, lo, inval);
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    cyc();
    cyc();
    reset = 1'b0;
    #1;
  endtask

  task automatic drain(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) cyc();
  endtask

  initial begin
    idle();
    do_reset();
    chk("rst_alloc_ok", 64'(alloc_ok), 64'(1));
    chk("rst_alloc_slot", 64'(alloc_slot), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_commit_valid", 64'(commit_valid), 64'(0));
    chk("rst_fwd_A_ready", 64'(fwd_A_ready), 64'(0));

    // In-order retire after out-of-order writeback
    alloc(1, 1'b0); alloc(2, 1'b0); alloc(3, 1'b0);
    chk("basic_count", 64'(count), 64'(3));
    wb(2, 1'b0, 32'h33, 1'b0);
    wb(1, 1'b0, 32'h22, 1'b0);
    chk("ooo_no_commit", 64'(commit_valid), 64'(0));
    wb(0, 1'b0, 32'h11, 1'b0);
    chk("r1_valid", 64'(commit_valid), 64'(1));
    chk("r1_dest", 64'(commit_dest_reg), 64'(1));
    chk("r1_lo", 64'(commit_result_lo), 64'(32'h11));
    chk("r1_count", 64'(count), 64'(3));
    cyc();
    chk("r2_dest", 64'(commit_dest_reg), 64'(2));
    chk("r2_lo", 64'(commit_result_lo), 64'(32'h22));
    chk("r2_count", 64'(count), 64'(2));
    cyc();
    chk("r3_dest", 64'(commit_dest_reg), 64'(3));
    chk("r3_lo", 64'(commit_result_lo), 64'(32'h33));
    cyc();
    chk("empty_commit", 64'(commit_valid), 64'(0));
    chk("empty_count", 64'(count), 64'(0));

    // Invalidated destination
    alloc(5, 1'b0);
    wb(3, 1'b0, 32'h55, 1'b1);
    chk("inval_valid", 64'(commit_valid), 64'(1));
    chk("inval_dvalid", 64'(commit_dest_reg_valid), 64'(0));
    cyc();

    // Forwarding latency
    alloc(6, 1'b0); alloc(7, 1'b0);
    fwd_A_slot = SLOT_W'(5);
    fwd_B_slot = SLOT_W'(4);
    #1;
    chk("fwd_before", 64'(fwd_A_ready), 64'(0));
    set_wb(5, 1'b0, 32'hABCD, 1'b0);
    #1;
`ifdef ROB_FWD_BYPASS_EN
    chk("fwd_bypass_ready", 64'(fwd_A_ready), 64'(1));
    chk("fwd_bypass_data", 64'(fwd_A_data), 64'(32'hABCD));
`else
    chk("fwd_wbcycle_ready", 64'(fwd_A_ready), 64'(0));
`endif
    cyc();
    chk("fwd_after_ready", 64'(fwd_A_ready), 64'(1));
    chk("fwd_after_data", 64'(fwd_A_data), 64'(32'hABCD));
    wb(4, 1'b0, 32'h44, 1'b0);
    drain(3);

    // Full buffer and wrap
    do_reset();
    for (int unsigned i = 0; i < DEPTH; i++) alloc(i % 32, 1'b0);
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_alloc_ok", 64'(alloc_ok), 64'(0));
    wb(0, 1'b0, 32'h100, 1'b0);
    alloc_req = 1'b1; alloc_dest_reg = 5'd9; alloc_dest_reg_valid = 1'b1; alloc_stream = 1'b1;
    #1;
    chk("full_retire_alloc_ok", 64'(alloc_ok), 64'(0));
    chk("full_retire_valid", 64'(commit_valid), 64'(1));
    cyc();
    chk("after_retire_count", 64'(count), 64'(DEPTH - 1));
    chk("after_retire_ok", 64'(alloc_ok), 64'(1));
    chk("wrap_slot", 64'(alloc_slot), 64'(0));
    alloc(9, 1'b1);
    chk("refull_count", 64'(count), 64'(DEPTH));
    wb(0, 1'b0, 32'hDEAD, 1'b0);
    for (int unsigned i = DEPTH - 1; i >= 1; i--) wb(i, 1'b0, 32'h200 + i, 1'b0);
    wb(0, 1'b1, 32'h900, 1'b0);
    drain(DEPTH + 4);
    chk("full_drained", 64'(count), 64'(0));

    // Flush
    do_reset();
    for (int unsigned i = 0; i < 6; i++) alloc(10 + i, 1'b0);
    flush_valid = 1'b1; flush_slot = SLOT_W'(2);
    cyc();
    chk("flush_count", 64'(count), 64'(3));
    chk("flush_tail", 64'(alloc_slot), 64'(3));
    wb(4, 1'b0, 32'h44, 1'b0);
    fwd_A_slot = SLOT_W'(4);
    #1;
    chk("flush_stale_wb", 64'(fwd_A_ready), 64'(0));
    alloc(20, 1'b1);
    wb(3, 1'b0, 32'h66, 1'b0);
    fwd_A_slot = SLOT_W'(3);
    #1;
    chk("wrong_stream_wb", 64'(fwd_A_ready), 64'(0));
    wb(3, 1'b1, 32'h77, 1'b0);
    chk("right_stream_ready", 64'(fwd_A_ready), 64'(1));
    chk("right_stream_data", 64'(fwd_A_data), 64'(32'h77));
    wb(0, 1'b0, 32'h70, 1'b0);
    flush_valid = 1'b1; flush_slot = SLOT_W'(1);
    set_wb(2, 1'b0, 32'h72, 1'b0);
    cyc();
    chk("flush_retire_count", 64'(count), 64'(1));
    chk("flush_retire_tail", 64'(alloc_slot), 64'(2));
    wb(1, 1'b0, 32'h71, 1'b0);
    drain(2);

    // Mixed traffic under the model
    do_reset();
    for (int unsigned n = 0; n < 600; n++) begin
      int unsigned sz, k;
      sz = q.size();
      fwd_A_slot = SLOT_W'($urandom_range(0, DEPTH - 1));
      fwd_B_slot = SLOT_W'($urandom_range(0, DEPTH - 1));
      if (sz > 0 && $urandom_range(0, 99) < 6) begin
        flush_valid = 1'b1;
        flush_slot = SLOT_W'((mhead + $urandom_range(0, sz - 1)) % DEPTH);
      end else if ($urandom_range(0, 99) < 60) begin
        alloc_req = 1'b1;
        alloc_dest_reg = 5'($urandom_range(0, 31));
        alloc_dest_reg_valid = 1'($urandom_range(0, 1));
        alloc_stream = 1'($urandom_range(0, 1));
      end
      if (sz > 0 && $urandom_range(0, 99) < 55) begin
        k = $urandom_range(0, sz - 1);
        if (!q[k].done)
          set_wb((mhead + k) % DEPTH,
                 ($urandom_range(0, 7) == 0) ? ~q[k].stream : q[k].stream,
                 $urandom, 1'($urandom_range(0, 3) == 0));
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
